// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the synchronous FIFO family.
//
// Contents:
//   ptr_width(addr_w)  - pointer width, {wrap, addr} = addr_w + 1 bits
//   fifo_depth(addr_w) - RAM depth, 2**addr_w entries
//   bin2gray(bin)      - binary to reflected gray code, up to 32 bits;
//                        callers cast the result down to their pointer width
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_cmp.sv
// fifo_ptr_cmp: combinational comparison of a write pointer against a read
// pointer, both {wrap, addr} binary.
//
// Parameters:
//   ADDR_W - RAM address width
// Ports:
//   wptr  in  ADDR_W+1  write pointer {wrap, addr}
//   rptr  in  ADDR_W+1  read pointer {wrap, addr}
//   full  out 1         addresses match while wrap bits differ
//   level out ADDR_W+1  occupancy, (wptr - rptr) mod 2**(ADDR_W+1)
module fifo_ptr_cmp #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [ADDR_W:0] wptr,
  input  logic [ADDR_W:0] rptr,
  output logic            full,
  output logic [ADDR_W:0] level
);

  // Equal addresses with opposite wrap bits means the writer has lapped the
  // reader by exactly one full depth.
  assign full = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  // The extra wrap bit makes the modular difference unambiguous, so a plain
  // unsigned subtraction yields 0..2**ADDR_W for any legal pointer pair.
  assign level = wptr - rptr;

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl: write-side pointer controller for the synchronous FIFO.
//
// Parameters:
//   ADDR_W - RAM address width, depth = 2**ADDR_W
//   AF_TH  - almost_full asserts when free entries <= AF_TH (1..2**ADDR_W-1)
// Ports:
//   clk         in  1         rising-edge clock
//   rst         in  1         asynchronous active-high reset
//   wr          in  1         write request
//   rptr        in  ADDR_W+1  read pointer {wrap, addr} from read controller
//   ovf_clr     in  1         clears sticky overflow
//   fifo_we     out 1         RAM write enable, wr & ~fifo_full (combinational)
//   waddr       out ADDR_W    RAM write address
//   wptr        out ADDR_W+1  registered write pointer {wrap, addr}
//   fifo_full   out 1         combinational full flag
//   almost_full out 1         registered almost-full flag
//   wr_level    out ADDR_W+1  registered fill level, 0..2**ADDR_W
//   overflow    out 1         sticky: write attempted while full
//   wptr_gray   out ADDR_W+1  registered gray code of the pointer
//                             (only when FIFO_WR_GRAY_PTR_EN is defined)
//
// Optional feature macro: FIFO_WR_GRAY_PTR_EN
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned AF_TH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W:0]   rptr,
  input  logic              ovf_clr,
  output logic              fifo_we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              fifo_full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
`ifdef FIFO_WR_GRAY_PTR_EN
  ,
  output logic [ADDR_W:0]   wptr_gray
`endif
);

  localparam int unsigned     PTR_W   = ptr_width(ADDR_W);
  localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(fifo_depth(ADDR_W));
  localparam logic [PTR_W-1:0] AF_TH_V = PTR_W'(AF_TH);

  logic [PTR_W-1:0] cur_level;
  logic [PTR_W-1:0] we_inc;
  logic [PTR_W-1:0] wptr_next;
  logic [PTR_W-1:0] next_level;
  logic [PTR_W-1:0] free_next;

  fifo_ptr_cmp #(
    .ADDR_W (ADDR_W)
  ) u_cmp (
    .wptr  (wptr),
    .rptr  (rptr),
    .full  (fifo_full),
    .level (cur_level)
  );

  assign fifo_we = wr & ~fifo_full;
  assign waddr   = wptr[ADDR_W-1:0];
  assign we_inc  = {{ADDR_W{1'b0}}, fifo_we};

  // Natural wrap of the PTR_W-bit adder toggles the wrap bit as addr rolls over.
  assign wptr_next = wptr + we_inc;

  // Level against the post-edge pointer; an accepted write can never push
  // past DEPTH because fifo_we is already blocked at full.
  assign next_level = cur_level + we_inc;
  assign free_next  = DEPTH_V - next_level;

  // Pointer, level and almost_full all advance on the same edge so that the
  // flag and the level seen by the requester are always consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      wr_level    <= '0;
      almost_full <= 1'b0;
    end else begin
      wptr        <= wptr_next;
      wr_level    <= next_level;
      almost_full <= (free_next <= AF_TH_V);
    end
  end

  // A set and a clear in the same cycle keep the flag set so a rejected
  // write is never lost behind a software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr && fifo_full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef FIFO_WR_GRAY_PTR_EN
  // Gray copy of the post-edge pointer, destined for a cross-domain
  // synchroniser where only one bit may change per increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_gray <= '0;
    end else begin
      wptr_gray <= PTR_W'(bin2gray(32'(wptr_next)));
    end
  end
`else
  // Without the gray output the binary pointer is the only published form.
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// tb_fifo_wr_ptr_ctrl: self-checking bench for fifo_wr_ptr_ctrl with
// ADDR_W = 4, AF_TH = 4. Directed scenarios with literal expectations are
// followed by a randomized phase; a reference model built on plain modular
// arithmetic is compared against the DUT on every falling edge.
// Optional feature macro honoured: FIFO_WR_GRAY_PTR_EN
module tb_fifo_wr_ptr_ctrl;

  localparam int ADDR_W = 4;
  localparam int AF_TH  = 4;
  localparam int DEPTH  = 16;
  localparam int PMOD   = 32;

  logic          clk;
  logic          rst;
  logic          wr;
  logic [ADDR_W:0] rptr;
  logic          ovf_clr;
  logic          fifo_we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0] wptr;
  logic          fifo_full;
  logic          almost_full;
  logic [ADDR_W:0] wr_level;
  logic          overflow;
`ifdef FIFO_WR_GRAY_PTR_EN
  logic [ADDR_W:0] wptr_gray;
`endif

  int checks;
  int failures;
  bit cmp_en;

  // Reference model state: number of accepted writes modulo PMOD, the sticky
  // overflow flag, and the registered level/almost-full the DUT must show.
  int m_wptr;
  int m_level;
  bit m_af;
  bit m_ovf;

  fifo_wr_ptr_ctrl #(
    .ADDR_W (ADDR_W),
    .AF_TH  (AF_TH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .rptr        (rptr),
    .ovf_clr     (ovf_clr),
    .fifo_we     (fifo_we),
    .waddr       (waddr),
    .wptr        (wptr),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
`ifdef FIFO_WR_GRAY_PTR_EN
    ,
    .wptr_gray   (wptr_gray)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit w, input int rp, input bit clr);
    wr      = w;
    rptr    = 5'(rp);
    ovf_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  function automatic int occupancy(input int wp, input int rp);
    return (wp + PMOD - rp) % PMOD;
  endfunction

  // Reference model: occupancy is the modular distance between writes and
  // reads; a request is honoured only if occupancy is below DEPTH.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wptr  <= 0;
      m_level <= 0;
      m_af    <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      automatic int  rp     = int'(rptr);
      automatic bit  isfull = (occupancy(m_wptr, rp) == DEPTH);
      automatic int  nw     = (wr && !isfull) ? (m_wptr + 1) % PMOD : m_wptr;
      automatic int  lvl    = occupancy(nw, rp);
      m_wptr  <= nw;
      m_level <= lvl;
      m_af    <= ((DEPTH - lvl) <= AF_TH);
      if (wr && isfull)  m_ovf <= 1'b1;
      else if (ovf_clr)  m_ovf <= 1'b0;
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      automatic bit e_full = (occupancy(m_wptr, int'(rptr)) == DEPTH);
      checkOutput("m_full",   32'(fifo_full),   32'(e_full));
      checkOutput("m_we",     32'(fifo_we),     32'(wr && !e_full));
      checkOutput("m_wptr",   32'(wptr),        32'(m_wptr));
      checkOutput("m_waddr",  32'(waddr),       32'(m_wptr % DEPTH));
      checkOutput("m_level",  32'(wr_level),    32'(m_level));
      checkOutput("m_af",     32'(almost_full), 32'(m_af));
      checkOutput("m_ovf",    32'(overflow),    32'(m_ovf));
`ifdef FIFO_WR_GRAY_PTR_EN
      checkOutput("m_gray",   32'(wptr_gray),   32'(m_wptr ^ (m_wptr >> 1)));
`endif
    end
  end

  initial begin
    int exp_addr [3];
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst      = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);

    // Reset then idle.
    #12;
    checkOutput("rst_wptr",  32'(wptr),        32'd0);
    checkOutput("rst_full",  32'(fifo_full),   32'd0);
    checkOutput("rst_level", 32'(wr_level),    32'd0);
    checkOutput("rst_ovf",   32'(overflow),    32'd0);
    checkOutput("rst_af",    32'(almost_full), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    tick();
    checkOutput("idle_wptr", 32'(wptr),    32'd0);
    checkOutput("idle_we",   32'(fifo_we), 32'd0);

    // Fill from empty: almost_full rises with level 12, full at 16.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 0, 1'b0);
      tick();
      checkOutput("fill_level", 32'(wr_level), 32'(k));
      checkOutput("fill_af",    32'(almost_full), 32'(k >= 12));
    end
    checkOutput("full_wptr",  32'(wptr),      32'b10000);
    checkOutput("full_flag",  32'(fifo_full), 32'd1);
    checkOutput("full_we",    32'(fifo_we),   32'd0);

    // Overflow at full, clear, then set-wins-over-clear.
    tick();
    checkOutput("ovf_set",   32'(overflow), 32'd1);
    checkOutput("ovf_wptr",  32'(wptr),     32'b10000);
    applyStimulus(1'b0, 0, 1'b1);
    tick();
    checkOutput("ovf_clr",   32'(overflow), 32'd0);
    applyStimulus(1'b1, 0, 1'b1);
    tick();
    checkOutput("ovf_both",  32'(overflow), 32'd1);

    // Read advancing on the edge of a write at full: rejected, then accepted.
    applyStimulus(1'b1, 0, 1'b0);
    tick();
    checkOutput("simul_hold", 32'(wptr), 32'b10000);
    applyStimulus(1'b1, 1, 1'b0);
    #1;
    checkOutput("simul_full", 32'(fifo_full), 32'd0);
    checkOutput("simul_we",   32'(fifo_we),   32'd1);
    tick();
    checkOutput("simul_wptr", 32'(wptr), 32'b10001);

    // Wrap: wptr = rptr = 15, three writes.
    applyStimulus(1'b0, 0, 1'b0);
    pulseReset();
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b1, 0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 15, 1'b0);
    tick();
    exp_addr[0] = 15;
    exp_addr[1] = 0;
    exp_addr[2] = 1;
    applyStimulus(1'b1, 15, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("wrap_waddr", 32'(waddr), 32'(exp_addr[k]));
      tick();
    end
    applyStimulus(1'b0, 15, 1'b0);
    checkOutput("wrap_wptr",  32'(wptr),     32'b10010);
    checkOutput("wrap_level", 32'(wr_level), 32'd3);

    // Async reset between edges at level 7.
    applyStimulus(1'b0, 0, 1'b0);
    pulseReset();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 0, 1'b0);
      tick();
    end
    checkOutput("mid_level", 32'(wr_level), 32'd7);
    applyStimulus(1'b0, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_wptr",  32'(wptr),        32'd0);
    checkOutput("arst_level", 32'(wr_level),    32'd0);
    checkOutput("arst_af",    32'(almost_full), 32'd0);
    checkOutput("arst_ovf",   32'(overflow),    32'd0);
    checkOutput("arst_full",  32'(fifo_full),   32'd0);
    checkOutput("arst_we",    32'(fifo_we),     32'd0);
`ifdef FIFO_WR_GRAY_PTR_EN
    checkOutput("arst_gray",  32'(wptr_gray),   32'd0);
`endif
    #2;
    rst = 1'b0;

    // Randomized traffic: the read pointer only advances while data is held.
    for (int n = 0; n < 3000; n++) begin
      automatic int rp = int'(rptr);
      tick();
      if (occupancy(m_wptr, rp) > 0 && $urandom_range(99) < 40)
        rp = (rp + 1) % PMOD;
      applyStimulus($urandom_range(99) < 70, rp, $urandom_range(99) < 10);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
